// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between one master port and the byte-wide memory slave.
// Address-phase and data-phase signals travel together; the slave modport returns hrdata/hreadyout/hresp.
// Flow control is the usual hready/hreadyout pair; the master stalls while hreadyout is low.
interface ahb_slave_mem_if;
    logic       hsel;
    logic [9:0] haddr;
    logic       hwrite;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic [7:0] hwdata;
    logic       hready;
    logic [7:0] hrdata;
    logic       hreadyout;
    logic       hresp;

    modport master (
        output hsel, haddr, hwrite, htrans, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite byte memory slave, DEPTH bytes; AHB_SLAVE_RANGE_ERR_EN turns out-of-range accesses into ERROR responses.
// Latency: data phase completes 1 + WAIT_STATES cycles after the address phase; ERROR takes exactly two cycles.
// Backpressure: hreadyout is held low during wait states and ERR1; address phases are only taken while hready is high.
module ahb_slave_mem #(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [7:0]    hrdata_q;
    logic [7:0]    mem [DEPTH];
    logic          accept;
    logic          err_flag;
    logic          rd_now;
    logic          hreadyout_int;
    logic          hresp_int;
    logic          unused_bits;

    assign accept = bus.hsel & bus.hready & bus.htrans[1];

`ifdef AHB_SLAVE_RANGE_ERR_EN
    assign err_flag = ({1'b0, bus.haddr} >= 11'(DEPTH));
`else
    assign err_flag = 1'b0;
`endif

    // Burst type and the BUSY/IDLE distinction carry no meaning here; beats are addressed individually.
    assign unused_bits = ^{bus.hburst, bus.htrans[0], bus.haddr};

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        hreadyout_int = 1'b1;
        hresp_int     = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                hresp_int = (state == S_ERR2);
                if (accept) begin
                    if (err_flag) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = 3'(WAIT_STATES - 1);
                    end else begin
                        state_nx = S_DATA;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                hreadyout_int = 1'b0;
                if (cnt == 3'd0) begin
                    state_nx = S_DATA;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            S_ERR1: begin
                hreadyout_int = 1'b0;
                hresp_int     = 1'b1;
                state_nx      = S_ERR2;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept && hreadyout_int) begin
                addr_q  <= bus.haddr[AW-1:0];
                write_q <= bus.hwrite;
            end
            if (rd_now) begin
                hrdata_q <= mem[addr_q];
            end
        end
    end

    // Storage is never reset. A write lands at the end of its DATA cycle, so the combinational
    // read port already sees it in the very next data phase (covers back-to-back with no wait states).
    always_ff @(posedge hclk) begin
        if (state == S_DATA && write_q) begin
            mem[addr_q] <= bus.hwdata;
        end
    end

    assign rd_now        = (state == S_DATA) && !write_q;
    assign bus.hrdata    = rd_now ? mem[addr_q] : hrdata_q;
    assign bus.hreadyout = hreadyout_int;
    assign bus.hresp     = hresp_int;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: one slave with one wait state (i1) and one with none (i0), sharing clock and reset.
// Expected values are hand-derived; range-error expectations follow AHB_SLAVE_RANGE_ERR_EN.
// hready is looped back from each slave's hreadyout, as with a single slave on the bus.
module tb_ahb_slave_mem;
    logic hclk;
    logic hreset;
    int   n_cmp;
    int   n_bad;

`ifdef AHB_SLAVE_RANGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    ahb_slave_mem_if i1 ();
    ahb_slave_mem_if i0 ();

    assign i1.hready = i1.hreadyout;
    assign i0.hready = i0.hreadyout;

    ahb_slave_mem #(.DEPTH(512), .WAIT_STATES(1)) dut1 (.hclk(hclk), .hreset(hreset), .bus(i1));
    ahb_slave_mem #(.DEPTH(512), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(i0));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic a1(input logic [9:0] a, input logic w, input logic [1:0] t);
        i1.hsel = 1'b1; i1.haddr = a; i1.hwrite = w; i1.htrans = t;
    endtask

    task automatic idle1();
        i1.hsel = 1'b0; i1.htrans = 2'b00; i1.hwrite = 1'b0;
    endtask

    task automatic a0(input logic [9:0] a, input logic w);
        i0.hsel = 1'b1; i0.haddr = a; i0.hwrite = w; i0.htrans = 2'b10;
    endtask

    task automatic idle0();
        i0.hsel = 1'b0; i0.htrans = 2'b00; i0.hwrite = 1'b0;
    endtask

    // Single in-range write / read on the one-wait-state slave (stimulus only).
    task automatic write1(input logic [9:0] a, input logic [7:0] d);
        a1(a, 1'b1, 2'b10);
        step();
        i1.hwdata = d;
        idle1();
        step();
        step();
    endtask

    task automatic read1(input logic [9:0] a, output logic [7:0] d);
        a1(a, 1'b0, 2'b10);
        step();
        idle1();
        step();
        d = i1.hrdata;
        step();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        #12;
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL reset_hreadyout: got %b want 1", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hresp !== 1'b0) begin $display("FAIL reset_hresp: got %b want 0", i1.hresp); n_bad++; end
        n_cmp++; if (i1.hrdata !== 8'h00) begin $display("FAIL reset_hrdata: got %h want 00", i1.hrdata); n_bad++; end
        n_cmp++; if (i0.hrdata !== 8'h00) begin $display("FAIL reset_hrdata_ws0: got %h want 00", i0.hrdata); n_bad++; end
        step();
        hreset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        a1(10'h010, 1'b1, 2'b10);
        step();
        n_cmp++; if (i1.hreadyout !== 1'b0) begin $display("FAIL wr_wait: got %b want 0", i1.hreadyout); n_bad++; end
        i1.hwdata = 8'hA5;
        a1(10'h010, 1'b0, 2'b10);
        step();
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL wr_data: got %b want 1", i1.hreadyout); n_bad++; end
        step();
        idle1();
        n_cmp++; if (i1.hreadyout !== 1'b0) begin $display("FAIL rd_wait: got %b want 0", i1.hreadyout); n_bad++; end
        step();
        n_cmp++; if (i1.hrdata !== 8'hA5) begin $display("FAIL rd_data: got %h want a5", i1.hrdata); n_bad++; end
        n_cmp++; if (i1.hresp !== 1'b0) begin $display("FAIL rd_hresp: got %b want 0", i1.hresp); n_bad++; end
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL rd_ready: got %b want 1", i1.hreadyout); n_bad++; end
        step();
        n_cmp++; if (i1.hrdata !== 8'hA5) begin $display("FAIL rd_hold: got %h want a5", i1.hrdata); n_bad++; end
    endtask

    task automatic test_back_to_back();
        a0(10'h020, 1'b1);
        step();
        n_cmp++; if (i0.hreadyout !== 1'b1) begin $display("FAIL b2b_wr_ready: got %b want 1", i0.hreadyout); n_bad++; end
        i0.hwdata = 8'h3C;
        a0(10'h020, 1'b0);
        step();
        idle0();
        n_cmp++; if (i0.hreadyout !== 1'b1) begin $display("FAIL b2b_rd_ready: got %b want 1", i0.hreadyout); n_bad++; end
        n_cmp++; if (i0.hrdata !== 8'h3C) begin $display("FAIL b2b_rd_data: got %h want 3c", i0.hrdata); n_bad++; end
        step();
    endtask

    task automatic test_burst();
        logic [7:0] d [4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        i1.hburst = 3'b011;
        a1(10'h100, 1'b1, 2'b10);
        step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (i1.hreadyout !== 1'b0) begin $display("FAIL burst_wr_wait%0d: got %b want 0", i, i1.hreadyout); n_bad++; end
            i1.hwdata = d[i];
            if (i < 3) a1(10'h100 + 10'(i + 1), 1'b1, 2'b11); else idle1();
            step();
            n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL burst_wr_data%0d: got %b want 1", i, i1.hreadyout); n_bad++; end
            step();
        end
        a1(10'h100, 1'b0, 2'b10);
        step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (i1.hreadyout !== 1'b0) begin $display("FAIL burst_rd_wait%0d: got %b want 0", i, i1.hreadyout); n_bad++; end
            if (i < 3) a1(10'h100 + 10'(i + 1), 1'b0, 2'b11); else idle1();
            step();
            n_cmp++; if (i1.hrdata !== d[i]) begin $display("FAIL burst_rd_data%0d: got %h want %h", i, i1.hrdata, d[i]); n_bad++; end
            step();
        end
        i1.hburst = 3'b000;
    endtask

    task automatic test_range_err();
        logic [7:0] r;
        write1(10'h000, 8'h5A);
        a1(10'h200, 1'b1, 2'b10);
        step();
        n_cmp++; if (i1.hreadyout !== 1'b0) begin $display("FAIL err1_ready: got %b want 0", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hresp !== ERR_EN) begin $display("FAIL err1_hresp: got %b want %b", i1.hresp, ERR_EN); n_bad++; end
        i1.hwdata = 8'hFF;
        idle1();
        step();
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL err2_ready: got %b want 1", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hresp !== ERR_EN) begin $display("FAIL err2_hresp: got %b want %b", i1.hresp, ERR_EN); n_bad++; end
        step();
        read1(10'h000, r);
        n_cmp++; if (r !== (ERR_EN ? 8'h5A : 8'hFF)) begin $display("FAIL err_wr_effect: got %h want %h", r, ERR_EN ? 8'h5A : 8'hFF); n_bad++; end
        a1(10'h300, 1'b0, 2'b10);
        step();
        idle1();
        step();
        n_cmp++; if (i1.hrdata !== (ERR_EN ? 8'h5A : 8'h11)) begin $display("FAIL err_rd_data: got %h want %h", i1.hrdata, ERR_EN ? 8'h5A : 8'h11); n_bad++; end
        step();
        n_cmp++; if (i1.hresp !== 1'b0) begin $display("FAIL err_after_idle: got %b want 0", i1.hresp); n_bad++; end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        write1(10'h005, 8'h12);
        read1(10'h005, r);
        a1(10'h005, 1'b1, 2'b10);
        step();
        i1.hwdata = 8'h77;
        idle1();
        #2;
        hreset = 1'b1;
        #1;
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL rstmid_ready: got %b want 1", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hrdata !== 8'h00) begin $display("FAIL rstmid_hrdata: got %h want 00", i1.hrdata); n_bad++; end
        step();
        hreset = 1'b0;
        step();
        read1(10'h005, r);
        n_cmp++; if (r !== 8'h12) begin $display("FAIL rstmid_mem: got %h want 12", r); n_bad++; end
    endtask

    task automatic test_busy_idle();
        logic [7:0] r;
        i1.hwdata = 8'hEE;
        a1(10'h005, 1'b1, 2'b01);
        step();
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL busy_ready: got %b want 1", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hrdata !== 8'h12) begin $display("FAIL busy_hrdata: got %h want 12", i1.hrdata); n_bad++; end
        a1(10'h005, 1'b1, 2'b00);
        step();
        n_cmp++; if (i1.hreadyout !== 1'b1) begin $display("FAIL idle_ready: got %b want 1", i1.hreadyout); n_bad++; end
        n_cmp++; if (i1.hresp !== 1'b0) begin $display("FAIL idle_hresp: got %b want 0", i1.hresp); n_bad++; end
        step();
        idle1();
        read1(10'h005, r);
        n_cmp++; if (r !== 8'h12) begin $display("FAIL busy_mem: got %h want 12", r); n_bad++; end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        hreset = 1'b1;
        i1.haddr = '0; i1.hburst = '0; i1.hwdata = '0;
        i0.haddr = '0; i0.hburst = '0; i0.hwdata = '0;
        idle1();
        idle0();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_burst();
        test_range_err();
        test_reset_mid();
        test_busy_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
